// File: rtl/egress_pkg.sv
// egress_pkg: shared types and helpers for the egress scheduler.
// Holds the head-metadata layout, the scheduler FSM encoding and the
// word-count helper used when a packet is granted.
package egress_pkg;

    localparam int WORD_W     = 32;
    localparam int META_LEN_W = 6;

    // Head metadata as written by the egress buffers.
    typedef struct packed {
        logic [1:0]            dest;
        logic [1:0]            src;
        logic [21:0]           time_delta;
        logic [META_LEN_W-1:0] len;
    } meta_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Words in a packet: (len + 1) blocks of wpb words each (8..512 for wpb = 8).
    function automatic logic [9:0] word_count(input logic [META_LEN_W-1:0] len,
                                              input int wpb);
        logic [9:0] blocks;
        blocks = {4'b0000, len} + 10'd1;
        return blocks * 10'(wpb);
    endfunction

endpackage

// File: rtl/egress_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Searches the request vector
// starting at ptr and wrapping from PORT_CNT-1 back to 0; returns a one-hot
// winner (all zero when nothing is requesting). PORT_CNT must be a power of
// two so the index addition wraps naturally.
module rr_arbiter #(
    parameter  int PORT_CNT = 4,
    localparam int PTR_W    = $clog2(PORT_CNT)
) (
    input  logic [PORT_CNT-1:0] req,
    input  logic [PTR_W-1:0]    ptr,
    output logic [PORT_CNT-1:0] gnt
);

    logic [PTR_W-1:0] idx_s;
    logic             found_s;

    // First requester at or after ptr wins.
    always_comb begin
        gnt     = '0;
        idx_s   = '0;
        found_s = 1'b0;
        for (int off = 0; off < PORT_CNT; off++) begin
            idx_s = ptr + PTR_W'(off);
            if (req[idx_s] && !found_s) begin
                gnt[idx_s] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/egress_sched.sv
// egress_sched: packet-granular round-robin scheduler sharing the software
// read path among the egress buffers. A grant is held until every word of
// the granted packet has been read, then the head metadata is popped and the
// pointer advances past the served buffer.
// Optional feature: define EGRESS_SCHED_STATS_EN to add per-port 16-bit
// popped-packet counters on output pkt_cnt.
module egress_sched
    import egress_pkg::*;
#(
    parameter  int PORT_CNT        = 4,
    parameter  int WORDS_PER_BLOCK = 8,
    localparam int PTR_W           = $clog2(PORT_CNT)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PORT_CNT-1:0]        meta_valid,
    input  logic [WORD_W*PORT_CNT-1:0] meta_in,
    input  logic                       rd_req,
    output logic [PORT_CNT-1:0]        rd_en,
    output logic [PORT_CNT-1:0]        meta_pop,
    output logic [PTR_W-1:0]           grant_port,
    output logic [WORD_W-1:0]          cur_meta,
    output logic                       busy,
    output logic                       pkt_done
`ifdef EGRESS_SCHED_STATS_EN
    ,
    output logic [16*PORT_CNT-1:0]     pkt_cnt
`endif
);

    state_t              state_r;
    logic [PTR_W-1:0]    rr_ptr_r;
    logic [9:0]          words_left_r;
    logic [PORT_CNT-1:0] win_onehot_s;
    logic [PTR_W-1:0]    win_idx_s;
    meta_t               win_meta_s;
    logic [PORT_CNT-1:0] grant_onehot_s;

    rr_arbiter #(.PORT_CNT(PORT_CNT)) u_arb (
        .req (meta_valid),
        .ptr (rr_ptr_r),
        .gnt (win_onehot_s)
    );

    assign grant_onehot_s = {{(PORT_CNT-1){1'b0}}, 1'b1} << grant_port;

    // Encode the winner index and select its head metadata.
    always_comb begin
        win_idx_s  = '0;
        win_meta_s = '0;
        for (int i = 0; i < PORT_CNT; i++) begin
            if (win_onehot_s[i]) begin
                win_idx_s  = PTR_W'(i);
                win_meta_s = meta_in[i*WORD_W +: WORD_W];
            end else begin
                win_idx_s = win_idx_s;
            end
        end
    end

    // Word strobe and end-of-packet flag follow rd_req within the cycle so
    // software can stream one word per clock.
    always_comb begin
        rd_en    = '0;
        pkt_done = 1'b0;
        if ((state_r == ST_XFER) && rd_req) begin
            rd_en    = grant_onehot_s;
            pkt_done = (words_left_r == 10'd1);
        end else begin
            rd_en    = '0;
        end
    end

    // Scheduler FSM: grant in IDLE, count words in XFER, pop and rotate in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= '0;
            words_left_r <= 10'd0;
            grant_port   <= '0;
            cur_meta     <= '0;
            busy         <= 1'b0;
            meta_pop     <= '0;
        end else begin
            meta_pop <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (|meta_valid) begin
                        grant_port   <= win_idx_s;
                        cur_meta     <= win_meta_s;
                        words_left_r <= word_count(win_meta_s.len, WORDS_PER_BLOCK);
                        busy         <= 1'b1;
                        state_r      <= ST_XFER;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_XFER: begin
                    // Grant is held here whatever meta_valid does.
                    if (rd_req) begin
                        words_left_r <= words_left_r - 10'd1;
                        if (words_left_r == 10'd1) begin
                            meta_pop <= grant_onehot_s;
                            state_r  <= ST_DONE;
                        end else begin
                            state_r  <= ST_XFER;
                        end
                    end else begin
                        words_left_r <= words_left_r;
                    end
                end
                ST_DONE: begin
                    busy     <= 1'b0;
                    rr_ptr_r <= grant_port + {{(PTR_W-1){1'b0}}, 1'b1};
                    state_r  <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef EGRESS_SCHED_STATS_EN
    // Per-port count of popped packets, wrapping at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_cnt <= '0;
        end else begin
            for (int i = 0; i < PORT_CNT; i++) begin
                if (meta_pop[i]) begin
                    pkt_cnt[16*i +: 16] <= pkt_cnt[16*i +: 16] + 16'd1;
                end else begin
                    pkt_cnt[16*i +: 16] <= pkt_cnt[16*i +: 16];
                end
            end
        end
    end
`endif

endmodule
